// File: rtl/addsub_arbiter_pkg.sv
// Shared types and helpers for the two-port adder/subtractor arbiter.
package addsub_arbiter_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Round-robin pick: prio breaks ties, otherwise the only valid port wins.
  function automatic logic pick_port(input logic v0, input logic v1, input logic prio);
    if (v0 && v1) begin
      return prio;
    end
    return v1;
  endfunction

endpackage

// File: rtl/n_bit_adder_sub.sv
// Ripple-free behavioural adder/subtractor: subtraction is a + ~b + 1.
module n_bit_adder_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic [WIDTH-1:0] answer_o,
  output logic             c_out_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff      = b_i ^ {WIDTH{c_in_i}};
    sum        = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in_i};
    answer_o   = sum[WIDTH-1:0];
    c_out_o    = sum[WIDTH];
    overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one adder/subtractor between two request/response ports.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_carry,
  output logic             rsp0_overflow,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_carry,
  output logic             rsp1_overflow,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;

  logic             win, accept;
  logic [WIDTH-1:0] answer;
  logic             c_out, overflow;

  n_bit_adder_sub #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i       (a_q),
    .b_i       (b_q),
    .c_in_i    (sub_q),
    .answer_o  (answer),
    .c_out_o   (c_out),
    .overflow_o(overflow)
  );

  always_comb begin
    win    = pick_port(req0_valid, req1_valid, prio_q);
    accept = (state_q == StIdle) && (req0_valid || req1_valid) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (gnt_q ? rsp1_ready : rsp0_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      gnt_d  = win;
      prio_d = ~win;
      a_d    = win ? req1_a : req0_a;
      b_d    = win ? req1_b : req0_b;
      sub_d  = win ? req1_sub : req0_sub;
    end
    if (state_q == StExec) begin
      res_d   = answer;
      carry_d = c_out;
      ovf_d   = overflow;
    end
  end

  // Result fields are shared; only rspN_valid says whose they are.
  always_comb begin
    req0_ready    = accept && !win;
    req1_ready    = accept && win;
    rsp0_valid    = (state_q == StResp) && !gnt_q;
    rsp1_valid    = (state_q == StResp) && gnt_q;
    busy          = (state_q != StIdle);
    rsp0_result   = res_q;
    rsp0_carry    = carry_q;
    rsp0_overflow = ovf_q;
    rsp1_result   = res_q;
    rsp1_carry    = carry_q;
    rsp1_overflow = ovf_q;
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: vector table, scoreboard and corner sequences.
module tb_addsub_arbiter;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sub, rsp0_valid, rsp0_ready, rsp0_carry, rsp0_overflow;
  logic        req1_valid, req1_ready, req1_sub, rsp1_valid, rsp1_ready, rsp1_carry, rsp1_overflow;
  logic [31:0] req0_a, req0_b, rsp0_result, req1_a, req1_b, rsp1_result;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  addsub_arbiter #(
    .WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sub     (req0_sub),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp0_result  (rsp0_result),
    .rsp0_carry   (rsp0_carry),
    .rsp0_overflow(rsp0_overflow),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sub     (req1_sub),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (rsp1_ready),
    .rsp1_result  (rsp1_result),
    .rsp1_carry   (rsp1_carry),
    .rsp1_overflow(rsp1_overflow),
    .busy         (busy)
  );

  // Reference: unsigned compare for carry, signed 64-bit range test for overflow.
  function automatic exp_t model(input int p, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    exp_t e;
    longint unsigned ua, ub;
    longint sa, sbv, sr;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.port = p;
    e.res = s ? a - b : a + b;
    e.c = s ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
    sr = s ? sa - sbv : sa + sbv;
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input int p, input logic [31:0] r, input logic c, input logic o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_rsp: port %0d result %0h with nothing outstanding", p, r);
    end else begin
      e = sb.pop_front();
      if (e.port != p || r !== e.res || c !== e.c || o !== e.o) begin
        errors++;
        $display("FAIL rsp: got port %0d res %0h c %0b o %0b expected port %0d res %0h c %0b o %0b",
                 p, r, c, o, e.port, e.res, e.c, e.o);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (rsp0_valid && rsp1_valid) begin
        errors++;
        $display("FAIL both_rsp_valid: got 1 1 expected at most one at %0t", $time);
      end
      if (rsp0_valid && rsp0_ready) check_rsp(0, rsp0_result, rsp0_carry, rsp0_overflow);
      if (rsp1_valid && rsp1_ready) check_rsp(1, rsp1_result, rsp1_carry, rsp1_overflow);
    end
  end

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input exp_t e);
    logic got;
    got = 1'b0;
    @(posedge clk);
    #1;
    if (p == 0) begin
      req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
    end
    chk("issue_accept", {31'd0, got}, 1);
    if (got) sb.push_back(e);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   grants;
    logic found;
    vecs[0] = '{1, 32'd2014, 32'd1167, 1'b1, 32'd847, 1'b1, 1'b0};
    vecs[1] = '{0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{1, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0; rsp0_ready = 1;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0; rsp1_ready = 1;
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", req0_ready, 0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_result", rsp0_result, 0);
    chk("reset_carry", rsp0_carry, 0);
    chk("reset_ovf", rsp0_overflow, 0);

    // Add on port 0 with latency checks.
    @(posedge clk);
    #1 req0_a = 32'd2014; req0_b = 32'd1167; req0_sub = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    chk("add_ready", req0_ready, 1);
    sb.push_back('{0, 32'd3181, 1'b0, 1'b0});
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("exec_rsp0_valid", rsp0_valid, 0);
    chk("exec_busy", busy, 1);
    @(negedge clk);
    chk("lat_rsp0_valid", rsp0_valid, 1);
    chk("lat_rsp1_valid", rsp1_valid, 0);
    drain();

    foreach (vecs[i]) begin
      e = '{vecs[i].port, vecs[i].res, vecs[i].c, vecs[i].o};
      issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sub, e);
      drain();
    end

    // Contention: both valid from reset, grants must alternate.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req0_sub = 1'(($urandom));
    req1_a = $urandom; req1_b = $urandom; req1_sub = 1'(($urandom));
    req0_valid = 1'b1; req1_valid = 1'b1;
    grants = 0;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("grant_order", {31'd0, req1_ready}, grants % 2);
        if (req1_ready) sb.push_back(model(1, req1_a, req1_b, req1_sub));
        else sb.push_back(model(0, req0_a, req0_b, req0_sub));
        grants++;
        @(posedge clk);
        #1;
        if (grants == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end else if (req1_ready) begin
          req1_a = $urandom; req1_b = $urandom; req1_sub = 1'(($urandom));
        end else begin
          req0_a = $urandom; req0_b = $urandom; req0_sub = 1'(($urandom));
        end
      end
    end
    chk("grant_count", grants, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Backpressure on port 0 while port 1 waits.
    rsp0_ready = 1'b0;
    @(posedge clk);
    #1 req0_a = 32'h1234_5678; req0_b = 32'h0FED_CBA9; req0_sub = 1'b1; req0_valid = 1'b1;
    req1_a = 32'd40; req1_b = 32'd2; req1_sub = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_grant0", req0_ready, 1);
    e = model(0, req0_a, req0_b, req0_sub);
    sb.push_back(e);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = rsp0_valid;
    end
    chk("bp_rsp_seen", {31'd0, found}, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_result", rsp0_result, e.res);
      chk("bp_busy", busy, 1);
      chk("bp_req1_ready", req1_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_then_grant1", req1_ready, 1);
    if (req1_ready) sb.push_back(model(1, req1_a, req1_b, req1_sub));
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();

    // Reset during EXEC drops the request and clears prio.
    @(posedge clk);
    #1 req0_a = 32'd5; req0_b = 32'd6; req0_sub = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    chk("drop_accept", req0_ready, 1);
    @(posedge clk);
    #1 req0_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 req0_a = 32'd100; req0_b = 32'd1; req0_sub = 1'b1; req0_valid = 1'b1;
    req1_a = 32'd7; req1_b = 32'd8; req1_sub = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_prio0", req0_ready, 1);
    if (req0_ready) sb.push_back(model(0, req0_a, req0_b, req0_sub));
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
